hsv_conv_sched: RTL and testbench
=================================

# hsv_conv_sched

Sequencer for the multi-cycle RGB→HSV converter in the cube-facelet colour path. It accepts RGB24 pixels on a valid/ready stream and buffers them in a small FIFO. For each pixel it issues a clear pulse, then a one-cycle start, then waits for done or a timeout. Each HSV24 result, or an error-flagged zero on timeout, goes out on a valid/ready stream. It sits between the pixel sampler and the facelet classifier, and owns the converter's rst/enable pins.

## Interface
- FIFO_DEPTH, 4, input pixel FIFO entries (power of 2, ≥2)
- CLR_CYCLES, 2, cycles conv_rst is held high before each start (≥1)
- TIMEOUT, 127, maximum WAIT cycles before abort (2..255)

- pclk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- rgb_valid  in  1  input pixel valid
- rgb_ready  out  1  = FIFO not full
- rgb_data  in  24  {R[23:16],G[15:8],B[7:0]}
- hsv_valid  out  1  result valid
- hsv_ready  in  1  downstream accept
- hsv_data  out  24  {H,S,V} from converter; 0 on timeout
- hsv_err  out  1  result is a timeout abort
- conv_rst  out  1  converter clear
- conv_enable  out  1  converter start pulse
- conv_rgb  out  24  pixel presented to converter
- conv_hsv  in  24  converter result
- conv_done  in  1  converter done
- busy  out  1  state ≠ IDLE or FIFO non-empty
- err_count  out  8  saturating timeout count

## Operation
- Reset values:
  - rgb_ready=1, hsv_valid=0, hsv_data=0, hsv_err=0
  - conv_rst=1 (drops on the first clock after rst release), conv_enable=0, conv_rgb=0
  - err_count=0, busy=0
  - state=IDLE, FIFO empty
- FIFO writes when rgb_valid&&rgb_ready. rgb_ready is 1 while the FIFO has a free entry; a write-when-full is impossible by construction.
- Output register is single-entry.
  - Cleared on hsv_valid&&hsv_ready.
  - Counts as free when empty or being drained the same cycle.
- IDLE: if FIFO non-empty and output register free, go to CLEAR. In the same cycle, load conv_rgb from the FIFO head.
- CLEAR: conv_rst=1 for CLR_CYCLES cycles (down-counter), then go to START.
- START: conv_enable=1 for exactly one cycle, FIFO pop, WAIT counter cleared, then go to WAIT.
- WAIT: counter increments each cycle.
  - On conv_done: hsv_data←conv_hsv, hsv_err←0, hsv_valid←1, go to IDLE.
  - On counter==TIMEOUT-1 without done: hsv_data←0, hsv_err←1, hsv_valid←1, err_count+1 (saturating at 255), go to IDLE.
  - conv_done together with the timeout in the same cycle: done wins, no error.
- conv_done outside WAIT is ignored.
- conv_rgb is registered and stable from CLEAR through WAIT.
- FIFO write and pop in the same cycle are both honoured; occupancy is unchanged.
- rst mid-conversion: everything returns to reset values immediately.
  - FIFO contents are discarded; no partial result is emitted.
  - conv_rst is asserted by reset itself.
- hsv_data/hsv_err hold stable while hsv_valid&&!hsv_ready.

## Timing
- Input accepted at cycle 0 (idle block, empty output) gives:
  - IDLE decision at cycle 1
  - CLEAR at cycles 2..1+CLR_CYCLES
  - START at 2+CLR_CYCLES
  - first WAIT cycle at 3+CLR_CYCLES
- With converter latency L (done sampled L cycles after the enable cycle), hsv_valid rises at 3+CLR_CYCLES+L. With defaults: 5+L.
- Back-to-back throughput with hsv_ready held high: one pixel per L+CLR_CYCLES+2 cycles.
- Timeout result: hsv_valid at 3+CLR_CYCLES+TIMEOUT.
- conv_enable is never high in the same cycle as conv_rst.

## Structure
- Package hsv_sched_pkg:
  - state enum IDLE/CLEAR/START/WAIT (2 bits)
  - PIX_W=24
  - width constants for the WAIT counter (8) and err_count (8)
- Sub-module pixel_fifo: synchronous FIFO with parameters WIDTH and DEPTH and async active-high reset. Ports: wr_en, wr_data, rd_en, rd_data (head, show-ahead), full, empty.
- The FSM, counters and output register stay in hsv_conv_sched.

## Test plan
- Single pixel (255,255,155), behavioural converter L=20 returning a fixed tag 0x2A64FF → conv_rst high cycles 2–3; conv_enable high only at cycle 4; hsv_valid at cycle 25 with hsv_data=0x2A64FF, hsv_err=0.
- Five pixels (255,255,155), (255,155,155), (255,55,155), (205,255,55), (205,55,255) sent back-to-back, L=20, hsv_ready=1:
  - rgb_ready drops after 4 writes.
  - Results come out in order, spaced 24 cycles apart.
  - Each conv_rgb matches its input.
- Converter never asserts done → hsv_valid at cycle 132 with hsv_data=0, hsv_err=1, err_count=1. The next pixel then converts normally.
- hsv_ready held low for 100 cycles with 3 pixels queued:
  - The first result holds stable.
  - No second CLEAR occurs until the handshake.
  - After release, all 3 results are delivered with no loss.
- rst asserted at cycle 15 of WAIT → all outputs at reset values at once; FIFO empty; no hsv_valid after release.
- Done and timeout coincide (converter L=TIMEOUT-1 measured from the first WAIT cycle) → hsv_err=0, data captured, err_count unchanged. Also force err_count to 255 and time out again → stays 255.

Source files
------------

// File: rtl/hsv_sched_pkg.sv
// Shared types and widths for the RGB->HSV converter sequencer.
package hsv_sched_pkg;
  localparam int PIX_W = 24;
  localparam int CNT_W = 8;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO; rd_data always presents the head entry.
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/hsv_conv_sched.sv
// Sequences one RGB pixel at a time through the external HSV converter:
// clear, start pulse, then wait for done or abort on timeout.
module hsv_conv_sched
  import hsv_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 127
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             rgb_valid,
  output logic             rgb_ready,
  input  logic [PIX_W-1:0] rgb_data,
  output logic             hsv_valid,
  input  logic             hsv_ready,
  output logic [PIX_W-1:0] hsv_data,
  output logic             hsv_err,
  output logic             conv_rst,
  output logic             conv_enable,
  output logic [PIX_W-1:0] conv_rgb,
  input  logic [PIX_W-1:0] conv_hsv,
  input  logic             conv_done,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [PIX_W-1:0] conv_rgb_reg, conv_rgb_next;
  logic             conv_rst_reg, conv_rst_next;
  logic             hsv_valid_reg, hsv_valid_next;
  logic [PIX_W-1:0] hsv_data_reg, hsv_data_next;
  logic             hsv_err_reg, hsv_err_next;
  logic [ERR_W-1:0] err_count_reg, err_count_next;
  logic [PIX_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             out_free;

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst     (rst),
    .wr_en   (rgb_valid),
    .wr_data (rgb_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The result slot may be refilled while it is being drained this cycle.
  assign out_free = !hsv_valid_reg || hsv_ready;

  always_comb begin
    state_next     = state_reg;
    clr_cnt_next   = clr_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    conv_rgb_next  = conv_rgb_reg;
    hsv_valid_next = hsv_valid_reg;
    hsv_data_next  = hsv_data_reg;
    hsv_err_next   = hsv_err_reg;
    err_count_next = err_count_reg;
    fifo_pop       = 1'b0;

    if (hsv_valid_reg && hsv_ready) hsv_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty && out_free) begin
          state_next    = CLEAR;
          clr_cnt_next  = CNT_W'(CLR_CYCLES - 1);
          conv_rgb_next = fifo_head;
        end
      end
      CLEAR: begin
        if (clr_cnt_reg == '0) state_next = START;
        else clr_cnt_next = clr_cnt_reg - 1'b1;
      end
      START: begin
        fifo_pop      = 1'b1;
        wait_cnt_next = '0;
        state_next    = WAIT;
      end
      WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        // done takes priority over a timeout landing on the same cycle
        if (conv_done) begin
          hsv_valid_next = 1'b1;
          hsv_data_next  = conv_hsv;
          hsv_err_next   = 1'b0;
          state_next     = IDLE;
        end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          hsv_valid_next = 1'b1;
          hsv_data_next  = '0;
          hsv_err_next   = 1'b1;
          if (err_count_reg != '1) err_count_next = err_count_reg + 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Registered so the converter is held in clear through reset itself.
    conv_rst_next = (state_next == CLEAR);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      clr_cnt_reg   <= '0;
      wait_cnt_reg  <= '0;
      conv_rgb_reg  <= '0;
      conv_rst_reg  <= 1'b1;
      hsv_valid_reg <= 1'b0;
      hsv_data_reg  <= '0;
      hsv_err_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      conv_rgb_reg  <= conv_rgb_next;
      conv_rst_reg  <= conv_rst_next;
      hsv_valid_reg <= hsv_valid_next;
      hsv_data_reg  <= hsv_data_next;
      hsv_err_reg   <= hsv_err_next;
      err_count_reg <= err_count_next;
    end
  end

  assign rgb_ready   = !fifo_full;
  assign hsv_valid   = hsv_valid_reg;
  assign hsv_data    = hsv_data_reg;
  assign hsv_err     = hsv_err_reg;
  assign conv_rst    = conv_rst_reg;
  assign conv_enable = (state_reg == START);
  assign conv_rgb    = conv_rgb_reg;
  assign busy        = (state_reg != IDLE) || !fifo_empty;
  assign err_count   = err_count_reg;
endmodule

// File: tb/tb_hsv_conv_sched.sv
// Scoreboard bench for hsv_conv_sched with a behavioural fixed-latency converter.
module tb_hsv_conv_sched;
  logic        pclk = 1'b0;
  logic        rst;
  logic        rgb_valid;
  logic        rgb_ready;
  logic [23:0] rgb_data;
  logic        hsv_valid;
  logic        hsv_ready;
  logic [23:0] hsv_data;
  logic        hsv_err;
  logic        conv_rst;
  logic        conv_enable;
  logic [23:0] conv_rgb;
  logic [23:0] conv_hsv = 24'h0;
  logic        conv_done = 1'b0;
  logic        busy;
  logic [7:0]  err_count;

  hsv_conv_sched dut (
    .pclk        (pclk),
    .rst         (rst),
    .rgb_valid   (rgb_valid),
    .rgb_ready   (rgb_ready),
    .rgb_data    (rgb_data),
    .hsv_valid   (hsv_valid),
    .hsv_ready   (hsv_ready),
    .hsv_data    (hsv_data),
    .hsv_err     (hsv_err),
    .conv_rst    (conv_rst),
    .conv_enable (conv_enable),
    .conv_rgb    (conv_rgb),
    .conv_hsv    (conv_hsv),
    .conv_done   (conv_done),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 pclk = ~pclk;

  int vec_count   = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Behavioural converter: done is high exactly conv_lat cycles after the enable cycle.
  int          conv_lat   = 20;
  bit          conv_never = 1'b0;
  bit          conv_swap  = 1'b0;
  logic [23:0] conv_tag   = 24'h2A64FF;
  int          rem        = 0;
  always @(posedge pclk) begin
    if (conv_rst) begin
      rem       <= 0;
      conv_done <= 1'b0;
    end else if (conv_enable) begin
      rem       <= conv_never ? 0 : conv_lat - 1;
      conv_done <= 1'b0;
    end else begin
      conv_done <= (rem == 1);
      if (rem > 0) rem <= rem - 1;
      conv_hsv  <= conv_swap ? {conv_rgb[7:0], conv_rgb[15:8], conv_rgb[23:16]} : conv_tag;
    end
  end

  typedef struct packed {
    logic        err;
    logic [23:0] data;
  } res_t;

  res_t        exp_q[$];
  logic [23:0] rgb_q[$];
  int          hs_cyc[$];
  int          en_cyc[$];
  int          clr_cyc[$];
  res_t        exp_e;
  bit          hold_prev = 1'b0;
  logic [23:0] data_prev;
  logic        err_prev;

  logic [23:0] pix [5] = '{24'hFFFF9B, 24'hFF9B9B, 24'hFF379B, 24'hCDFF37, 24'hCD37FF};
  logic [23:0] swp [5] = '{24'h9BFFFF, 24'h9B9BFF, 24'h9B37FF, 24'h37FFCD, 24'hFF37CD};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    vec_count++;
    miscompares++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: sampled just after the falling edge, once the bench has driven its inputs.
  initial begin
    forever begin
      @(negedge pclk);
      #1;
      if (!rst) begin
        if (conv_rst) clr_cyc.push_back(cyc);
        if (conv_enable) begin
          en_cyc.push_back(cyc);
          chk("enable_with_clear", conv_rst, 0);
          if (rgb_q.size() == 0) fail("conv_rgb", "enable with no pixel queued");
          else chk("conv_rgb", conv_rgb, rgb_q.pop_front());
        end
        if (hold_prev) begin
          chk("hold_valid", hsv_valid, 1);
          chk("hold_data", hsv_data, data_prev);
          chk("hold_err", hsv_err, err_prev);
        end
        if (hsv_valid && hsv_ready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) fail("hsv_result", "result delivered with none expected");
          else begin
            exp_e = exp_q.pop_front();
            chk("hsv_data", hsv_data, exp_e.data);
            chk("hsv_err", hsv_err, exp_e.err);
          end
        end
        hold_prev = hsv_valid && !hsv_ready;
        data_prev = hsv_data;
        err_prev  = hsv_err;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [23:0] px, output int t);
    int n = 0;
    t = cyc;
    while (!rgb_ready && n < 1000) begin
      @(negedge pclk);
      n++;
    end
    if (!rgb_ready) begin
      fail("send", "rgb_ready never returned");
    end else begin
      rgb_valid = 1'b1;
      rgb_data  = px;
      t         = cyc;
      rgb_q.push_back(px);
      @(negedge pclk);
      rgb_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || hsv_valid || exp_q.size() != 0) && n < bound) begin
      @(negedge pclk);
      n++;
    end
    if (busy || hsv_valid || exp_q.size() != 0) fail("wait_idle", "block did not drain in time");
    @(negedge pclk);
  endtask

  task automatic clear_logs();
    hs_cyc.delete();
    en_cyc.delete();
    clr_cyc.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rgb_ready"}, rgb_ready, 1);
    chk({tag, "_hsv_valid"}, hsv_valid, 0);
    chk({tag, "_hsv_data"}, hsv_data, 0);
    chk({tag, "_hsv_err"}, hsv_err, 0);
    chk({tag, "_conv_rst"}, conv_rst, 1);
    chk({tag, "_conv_enable"}, conv_enable, 0);
    chk({tag, "_conv_rgb"}, conv_rgb, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int t0;
    int tt;
    rst       = 1'b1;
    rgb_valid = 1'b0;
    rgb_data  = 24'h0;
    hsv_ready = 1'b1;
    repeat (3) @(negedge pclk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge pclk);
    chk("conv_rst_release", conv_rst, 0);

    // Single pixel, L=20
    clear_logs();
    conv_swap = 1'b0; conv_tag = 24'h2A64FF; conv_lat = 20;
    send(pix[0], t0);
    exp_q.push_back({1'b0, 24'h2A64FF});
    wait_idle(500);
    chk("single_clr_count", clr_cyc.size(), 2);
    if (clr_cyc.size() == 2) begin
      chk("single_clr_first", clr_cyc[0] - t0, 2);
      chk("single_clr_last", clr_cyc[1] - t0, 3);
    end
    chk("single_en_count", en_cyc.size(), 1);
    if (en_cyc.size() == 1) chk("single_en_cycle", en_cyc[0] - t0, 4);
    chk("single_res_count", hs_cyc.size(), 1);
    if (hs_cyc.size() == 1) chk("single_valid_cycle", hs_cyc[0] - t0, 25);

    // Five pixels back-to-back
    clear_logs();
    conv_swap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(pix[i], tt);
      if (i == 0) t0 = tt;
      exp_q.push_back({1'b0, swp[i]});
    end
    chk("b2b_ready_full", rgb_ready, 0);
    send(pix[4], tt);
    exp_q.push_back({1'b0, swp[4]});
    wait_idle(1000);
    chk("b2b_res_count", hs_cyc.size(), 5);
    if (hs_cyc.size() == 5) begin
      chk("b2b_first_cycle", hs_cyc[0] - t0, 25);
      for (int i = 0; i < 4; i++) chk("b2b_spacing", hs_cyc[i+1] - hs_cyc[i], 24);
    end

    // Converter never finishes: timeout, then a normal conversion
    clear_logs();
    conv_never = 1'b1;
    send(pix[0], t0);
    exp_q.push_back({1'b1, 24'h0});
    wait_idle(500);
    chk("timeout_res_count", hs_cyc.size(), 1);
    if (hs_cyc.size() == 1) chk("timeout_valid_cycle", hs_cyc[0] - t0, 132);
    chk("timeout_err_count", err_count, 1);
    conv_never = 1'b0; conv_swap = 1'b0; conv_tag = 24'h5A3C01;
    send(pix[3], t0);
    exp_q.push_back({1'b0, 24'h5A3C01});
    wait_idle(500);
    chk("after_timeout_err_count", err_count, 1);

    // Downstream stalled for 100 cycles with three pixels queued
    clear_logs();
    hsv_ready = 1'b0; conv_swap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(pix[i], tt);
      exp_q.push_back({1'b0, swp[i]});
    end
    repeat (100) @(negedge pclk);
    chk("stall_valid", hsv_valid, 1);
    chk("stall_data", hsv_data, swp[0]);
    chk("stall_single_clear", clr_cyc.size(), 2);
    hsv_ready = 1'b1;
    wait_idle(1000);
    chk("stall_res_count", hs_cyc.size(), 3);

    // Reset during WAIT
    clear_logs();
    conv_never = 1'b1;
    send(pix[0], t0);
    send(pix[1], tt);
    send(pix[2], tt);
    while (cyc < t0 + 20) @(negedge pclk);
    chk("midwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_values("midwait_reset");
    exp_q.delete();
    rgb_q.delete();
    @(negedge pclk);
    rst = 1'b0;
    conv_never = 1'b0;
    clear_logs();
    repeat (200) @(negedge pclk);
    chk("post_reset_results", hs_cyc.size(), 0);
    chk("post_reset_enables", en_cyc.size(), 0);
    chk("post_reset_busy", busy, 0);

    // Done coincides with the timeout cycle
    clear_logs();
    conv_swap = 1'b0; conv_tag = 24'h123456; conv_lat = 127;
    send(pix[1], t0);
    exp_q.push_back({1'b0, 24'h123456});
    wait_idle(500);
    chk("coincide_res_count", hs_cyc.size(), 1);
    if (hs_cyc.size() == 1) chk("coincide_valid_cycle", hs_cyc[0] - t0, 132);
    chk("coincide_err_count", err_count, 0);

    // Saturate err_count, then one more timeout
    conv_never = 1'b1;
    for (int i = 0; i < 255; i++) begin
      send(pix[i % 5], tt);
      exp_q.push_back({1'b1, 24'h0});
    end
    wait_idle(1000);
    chk("err_count_255", err_count, 255);
    send(pix[2], tt);
    exp_q.push_back({1'b1, 24'h0});
    wait_idle(500);
    chk("err_count_saturated", err_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
